// File: rtl/apple_sound_pkg.sv
// Shared types and helpers for the Apple II style sound blocks.
package apple_sound_pkg;

  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DECAY  = 2'd2
  } chan_state_t;

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
    input logic signed [SAT_MAX_W-1:0] value,
    input int unsigned                 width
  );
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/apple_speaker_channel.sv
// One toggle soft-switch channel: address decode, polarity bit, idle timeout
// and linear decay ramp producing a signed PCM contribution.
module apple_speaker_channel
  import apple_sound_pkg::*;
#(
  parameter logic [15:0] ADDR          = 16'hC030,
  parameter int unsigned SAMPLE_WIDTH  = 16,
  parameter int unsigned AMPLITUDE     = 32'h2000,
  parameter int unsigned TIMEOUT_WIDTH = 20,
  parameter int unsigned DECAY_STEP    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_phi1_posedge,
  input  logic [15:0]                    i_addr,
  input  logic                           i_m2sel_n,
  input  logic                           i_enable,
  input  logic                           i_tick,
  output logic signed [SAMPLE_WIDTH-1:0] o_contrib_c,
  output logic                           o_active
);

  localparam int unsigned LEVEL_W = SAMPLE_WIDTH - 1;
  localparam logic [LEVEL_W-1:0]       AMP_L   = LEVEL_W'(AMPLITUDE);
  localparam logic [LEVEL_W-1:0]       STEP_L  = LEVEL_W'(DECAY_STEP);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = TIMEOUT_WIDTH'(1);

  chan_state_t              r_state;
  chan_state_t              w_state_nxt;
  logic                     r_bit;
  logic                     w_bit_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_count;
  logic [TIMEOUT_WIDTH-1:0] w_count_nxt;
  logic [LEVEL_W-1:0]       r_level;
  logic [LEVEL_W-1:0]       w_level_nxt;
  logic                     w_toggle;
  logic signed [SAMPLE_WIDTH-1:0] w_mag;

  assign w_toggle = i_phi1_posedge && !i_m2sel_n && (i_addr == ADDR);
  assign w_mag    = $signed({1'b0, r_level});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bit    <= 1'b0;
      r_count  <= '0;
      r_level  <= '0;
      o_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bit    <= w_bit_nxt;
      r_count  <= w_count_nxt;
      r_level  <= w_level_nxt;
      o_active <= (w_state_nxt != IDLE);
    end
  end

  // A toggle outranks both timeout expiry and a decay step in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_level_nxt = r_level;
    w_bit_nxt   = r_bit ^ w_toggle;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
      w_level_nxt = '0;
    end else if (w_toggle) begin
      w_state_nxt = ACTIVE;
      w_count_nxt = '1;
      w_level_nxt = AMP_L;
    end else begin
      case (r_state)
        ACTIVE: begin
          if (r_count <= CNT_ONE) begin
            w_state_nxt = DECAY;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count - CNT_ONE;
          end
        end
        DECAY: begin
          if (i_tick) begin
            if (r_level <= STEP_L) begin
              w_level_nxt = '0;
              w_state_nxt = IDLE;
            end else begin
              w_level_nxt = r_level - STEP_L;
            end
          end
        end
        default: begin
          w_count_nxt = '0;
          w_level_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_contrib_c = '0;
    if (r_state != IDLE) begin
      o_contrib_c = r_bit ? w_mag : -w_mag;
    end
  end

endmodule

// File: rtl/apple_speaker_mixer.sv
// N-channel toggle speaker mixer: per-channel ramps, saturating sum and a
// fixed-rate sample output strobe.
module apple_speaker_mixer
  import apple_sound_pkg::*;
#(
  parameter int unsigned                  NUM_CHANNELS  = 2,
  parameter logic [16*NUM_CHANNELS-1:0]   CHANNEL_ADDRS = {16'hC020, 16'hC030},
  parameter int unsigned                  SAMPLE_WIDTH  = 16,
  parameter int unsigned                  AMPLITUDE     = 32'h2000,
  parameter int unsigned                  TIMEOUT_WIDTH = 20,
  parameter int unsigned                  DECAY_STEP    = 64,
  parameter int unsigned                  SAMPLE_DIV    = 1125
) (
  input  logic                           clk_logic,
  input  logic                           system_reset,
  input  logic                           phi1_posedge,
  input  logic [15:0]                    addr,
  input  logic                           m2sel_n,
  input  logic [NUM_CHANNELS-1:0]        enable,
  output logic signed [SAMPLE_WIDTH-1:0] sample_o,
  output logic                           sample_valid_o,
  output logic [NUM_CHANNELS-1:0]        active_o
);

  localparam int unsigned MIX_W   = SAMPLE_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int unsigned PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);

  logic [PRESC_W-1:0]             r_presc;
  logic                           w_tick;
  logic signed [SAMPLE_WIDTH-1:0] w_contrib [NUM_CHANNELS];
  logic signed [MIX_W-1:0]        w_sum;
  logic signed [SAT_MAX_W-1:0]    w_sat;
  logic signed [SAMPLE_WIDTH-1:0] w_mix;

  assign w_tick = (r_presc == PRESC_LAST);

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    apple_speaker_channel #(
      .ADDR          (CHANNEL_ADDRS[16*gi +: 16]),
      .SAMPLE_WIDTH  (SAMPLE_WIDTH),
      .AMPLITUDE     (AMPLITUDE),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .DECAY_STEP    (DECAY_STEP)
    ) u_chan (
      .clk            (clk_logic),
      .rst            (system_reset),
      .i_phi1_posedge (phi1_posedge),
      .i_addr         (addr),
      .i_m2sel_n      (m2sel_n),
      .i_enable       (enable[gi]),
      .i_tick         (w_tick),
      .o_contrib_c    (w_contrib[gi]),
      .o_active       (active_o[gi])
    );
  end

  // Wide enough that the sum never wraps before saturation.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_sum = w_sum + MIX_W'(w_contrib[i]);
    end
  end

  assign w_sat = sat_signed(SAT_MAX_W'(w_sum), SAMPLE_WIDTH);
  assign w_mix = SAMPLE_WIDTH'(w_sat);

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      r_presc        <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      r_presc        <= w_tick ? '0 : r_presc + PRESC_W'(1);
      sample_valid_o <= w_tick;
      if (w_tick) begin
        sample_o <= w_mix;
      end
    end
  end

endmodule

// File: doc/apple_speaker_mixer.md
# apple_speaker_mixer

Parametrised successor to the single-bit Apple II speaker. It tracks N toggle-type soft-switch channels, such as $C030 speaker and $C020 cassette out. Each channel produces a signed PCM contribution with an idle timeout followed by a linear decay ramp instead of an abrupt cut, which avoids clicks. The block mixes the channels with saturation and emits samples at a fixed rate to the audio mixer/I2S path.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of toggle channels (1..8)
- CHANNEL_ADDRS, {16'hC020,16'hC030}, packed 16-bit addresses; channel i uses bits [16*i +: 16]
- SAMPLE_WIDTH, 16, signed output width
- AMPLITUDE, 16'h2000, full-scale per-channel level, unsigned, must be < 2^(SAMPLE_WIDTH-1)
- TIMEOUT_WIDTH, 20, idle countdown width; timeout = 2^TIMEOUT_WIDTH-1 clocks
- DECAY_STEP, 64, level decrement per sample tick in DECAY
- SAMPLE_DIV, 1125, clocks per output sample (54 MHz / 48 kHz)

Ports:
- clk_logic  in  1  system logic clock; the only clock
- system_reset  in  1  asynchronous, active-high reset
- phi1_posedge  in  1  one-cycle bus strobe
- addr  in  16  bus address
- m2sel_n  in  1  active-low memory select qualifier
- enable  in  NUM_CHANNELS  per-channel enable
- sample_o  out  SAMPLE_WIDTH  signed mixed sample; reset 0
- sample_valid_o  out  1  one-cycle pulse when sample_o updates; reset 0
- active_o  out  NUM_CHANNELS  channel state != IDLE; reset 0

## Operation
- Toggle event for channel i:
  - Condition: phi1_posedge && !m2sel_n && addr == CHANNEL_ADDRS[i].
  - Effect: inverts bit_i.
  - Aliased addresses toggle every matching channel.
- Per-channel FSM, states IDLE, ACTIVE, DECAY:
  - Any state, on toggle with enable[i]: go to ACTIVE, countdown reloads to all-ones, level = AMPLITUDE.
  - ACTIVE: countdown decrements each clock. At countdown == 0 with no toggle, go to DECAY.
  - DECAY: on each sample tick, level = level - DECAY_STEP, saturating at 0. When level reaches 0, go to IDLE.
  - IDLE: level = 0.
- enable[i] low:
  - Forces state IDLE, level 0 and contribution 0.
  - bit_i still toggles.
- Contribution:
  - bit_i ? +level : -level in ACTIVE/DECAY.
  - 0 in IDLE.
- Mix:
  - Signed sum of contributions at width SAMPLE_WIDTH + clog2(NUM_CHANNELS) + 1.
  - Saturated to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
- Simultaneous events:
  - Toggle beats countdown expiry.
  - Toggle beats a decay step in the same cycle; level becomes AMPLITUDE with no decrement.
- Reset, including mid-operation:
  - Bits, countdowns, levels and prescaler go to 0; states go to IDLE.
  - All outputs go to 0 on assertion.

## Timing
- Prescaler counts 0..SAMPLE_DIV-1 and wraps. Tick = (prescaler == SAMPLE_DIV-1).
- On the tick cycle:
  - The mix is computed from current channel state.
  - It is registered into sample_o on the next edge, with sample_valid_o high for exactly that one cycle.
- sample_o holds between pulses. Pulse period is exactly SAMPLE_DIV clocks; the first pulse comes SAMPLE_DIV clocks after reset release.
- Toggle-to-output latency:
  - bit/state update 1 clock after the strobe cycle.
  - Visible at the next sample_valid_o.
- active_o is registered with state, 1 clock after the event.
- Decay duration is ceil(AMPLITUDE / DECAY_STEP) ticks.

## Structure
- Shared package apple_sound_pkg:
  - chan_state_t enum {IDLE, ACTIVE, DECAY}.
  - Saturation function sat_signed(width).
- Sub-module apple_speaker_channel, one per channel via generate:
  - Holds address compare, bit, countdown, FSM and level.
  - Outputs signed contribution and active.
- Top holds the prescaler, adder tree, saturation and output registers.

## Test plan
- Toggle and polarity: defaults, one $C030 strobe.
  - Next sample_valid_o gives sample_o = 16'h2000, active_o = 2'b01.
  - A second strobe gives 16'hE000.
- Qualifiers: strobe at $C031, or at $C030 with m2sel_n = 1 -> sample_o stays 0, active_o = 0.
- Timeout and decay: TIMEOUT_WIDTH = 4, SAMPLE_DIV = 4, one toggle.
  - DECAY entered 15 clocks after the bit update.
  - sample_o steps 0x2000, 0x1FC0, 0x1F80, ...
  - IDLE after 128 ticks, with active_o cleared.
- Saturation: AMPLITUDE = 16'h6000, both channels toggled once.
  - sample_o = 16'h7FFF.
  - Toggling both again gives 16'h8000.
- Decay recovery and enable: toggle during DECAY in the same cycle as a tick -> level exactly 0x2000. Then drop enable[0] -> next sample 0, active_o[0] = 0.
- Reset mid-ACTIVE: assert system_reset between ticks -> all outputs 0 immediately; first pulse after release comes SAMPLE_DIV clocks later with value 0.
